mul_job_sched: RTL and testbench

- Round-robin scheduler that shares one 24x24 multiply + popcount engine among NREQ requesters.
- Accepts one job at a time over a per-requester valid/ready handshake and issues a start pulse to the engine.
- Waits for the engine's done (with watchdog timeout) and returns the result to the granted requester.
- Sits between the bus-side register front-ends and the arithmetic engine, replacing single-master direct control of it.

---
 rtl/mul_sched_pkg.sv | 21 ++
 rtl/mul_rr_pick.sv | 29 ++
 rtl/mul_job_sched.sv | 126 ++++++++++++
 tb/tb_mul_job_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the multiply-engine job scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } sched_state_t;

    localparam int DEF_AW    = 24;
    localparam int DEF_WW    = 32;
    localparam int DEF_LW    = 6;
    localparam int JOB_CNT_W = 16;
    localparam int ERR_CNT_W = 8;

    // Index width for a requester pointer; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Circular priority picker: first asserted request at or after rr_ptr.
module mul_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_job_sched.sv
// Round-robin scheduler sharing one multiply/popcount engine among NREQ requesters,
// with a watchdog that aborts jobs whose engine never reports done.
module mul_job_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = DEF_AW,
    parameter int WW      = DEF_WW,
    parameter int LW      = DEF_LW,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_a1,
    input  logic [NREQ*AW-1:0]   req_a2,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [WW-1:0]        rsp_w,
    output logic [LW-1:0]        rsp_l,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic                 eng_start,
    output logic [AW-1:0]        eng_a1,
    output logic [AW-1:0]        eng_a2,
    input  logic                 eng_done,
    input  logic [WW-1:0]        eng_w,
    input  logic [LW-1:0]        eng_l,
    input  logic                 eng_ovf,
    output logic                 busy,
    output logic [JOB_CNT_W-1:0] job_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int PW = ptr_w(NREQ);
    // One extra bit so TIMEOUT-1 always fits regardless of whether TIMEOUT is a power of two.
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t    state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   g_idx;
    logic [TW-1:0]   timer;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    mul_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            g_idx     <= '0;
            timer     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_w     <= '0;
            rsp_l     <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
            eng_a1    <= '0;
            eng_a2    <= '0;
            job_count <= '0;
            err_count <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick_any) begin
                        g_idx     <= pick_idx;
                        eng_a1    <= req_a1[int'(pick_idx)*AW +: AW];
                        eng_a2    <= req_a2[int'(pick_idx)*AW +: AW];
                        req_ready <= pick_gnt;
                        eng_start <= 1'b1;
                        timer     <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A done arriving on the timeout edge still wins over the abort.
                    if (eng_done) begin
                        rsp_w     <= eng_w;
                        rsp_l     <= eng_l;
                        rsp_ovf   <= eng_ovf;
                        rsp_err   <= 1'b0;
                        rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << g_idx;
                        state     <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_w     <= '0;
                        rsp_l     <= '0;
                        rsp_ovf   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << g_idx;
                        if (err_count != {ERR_CNT_W{1'b1}})
                            err_count <= err_count + ERR_CNT_W'(1);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    job_count <= job_count + JOB_CNT_W'(1);
                    rr_ptr    <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_job_sched.sv
// Directed self-checking bench for mul_job_sched with a simple engine model.
module tb_mul_job_sched;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        en;
    logic [3:0]  req_valid;
    logic [95:0] req_a1;
    logic [95:0] req_a2;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_w;
    logic [5:0]  rsp_l;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        eng_start;
    logic [23:0] eng_a1;
    logic [23:0] eng_a2;
    logic        eng_done;
    logic [31:0] eng_w;
    logic [5:0]  eng_l;
    logic        eng_ovf;
    logic        busy;
    logic [15:0] job_count;
    logic [7:0]  err_count;

    mul_job_sched dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .en        (en),
        .req_valid (req_valid),
        .req_a1    (req_a1),
        .req_a2    (req_a2),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_w     (rsp_w),
        .rsp_l     (rsp_l),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_a1    (eng_a1),
        .eng_a2    (eng_a2),
        .eng_done  (eng_done),
        .eng_w     (eng_w),
        .eng_l     (eng_l),
        .eng_ovf   (eng_ovf),
        .busy      (busy),
        .job_count (job_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Engine model: after seeing eng_start, wait eng_dly cycles then pulse done (never if < 0).
    int          eng_dly = 3;
    logic [31:0] m_w     = 32'h0;
    logic [5:0]  m_l     = 6'h0;
    logic        m_ovf   = 1'b0;

    initial begin
        eng_done = 1'b0;
        eng_w    = '0;
        eng_l    = '0;
        eng_ovf  = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && eng_dly >= 0) begin
                repeat (eng_dly) @(negedge clk);
                eng_done = 1'b1;
                eng_w    = m_w;
                eng_l    = m_l;
                eng_ovf  = m_ovf;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    int t_rdy;
    int t_rsp;

    task automatic wait_ready(input string tag, output logic [3:0] r);
        r = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                r     = req_ready;
                t_rdy = cyc;
                return;
            end
        end
        check({tag, "_ready_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(input string tag, output logic [3:0] v);
        v = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) begin
                v     = rsp_valid;
                t_rsp = cyc;
                return;
            end
        end
        check({tag, "_rsp_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    logic [3:0] r, v, expg;
    int         seen;

    initial begin
        n_reset   = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_a1    = '0;
        req_a2    = '0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rspv", 64'(rsp_valid), 64'(0));
        check("rst_start", 64'(eng_start), 64'(0));
        check("rst_jobs", 64'(job_count), 64'(0));
        check("rst_errs", 64'(err_count), 64'(0));
        @(negedge clk);
        n_reset = 1'b1;

        // Single job on requester 0
        eng_dly = 3; m_w = 32'h0000000F; m_l = 6'd4; m_ovf = 1'b0;
        @(negedge clk);
        req_a1[0 +: 24] = 24'h000003;
        req_a2[0 +: 24] = 24'h000005;
        req_valid = 4'b0001;
        wait_ready("t1", r);
        check("t1_ready", 64'(r), 64'(4'b0001));
        check("t1_start", 64'(eng_start), 64'(1));
        check("t1_a1", 64'(eng_a1), 64'(24'h3));
        check("t1_a2", 64'(eng_a2), 64'(24'h5));
        check("t1_busy", 64'(busy), 64'(1));
        req_valid = '0;
        @(negedge clk);
        check("t1_ready_pulse", 64'(req_ready), 64'(0));
        check("t1_start_pulse", 64'(eng_start), 64'(0));
        wait_rsp("t1", v);
        check("t1_rspv", 64'(v), 64'(4'b0001));
        check("t1_lat", 64'(t_rsp - t_rdy), 64'(4));
        check("t1_w", 64'(rsp_w), 64'(32'hF));
        check("t1_l", 64'(rsp_l), 64'(4));
        check("t1_err", 64'(rsp_err), 64'(0));
        @(negedge clk);
        check("t1_rspv_pulse", 64'(rsp_valid), 64'(0));
        check("t1_jobs", 64'(job_count), 64'(1));

        // Fairness: all requesters held high for five jobs from a fresh pointer
        do_reset();
        eng_dly = 1;
        for (int i = 0; i < 4; i++) begin
            req_a1[i*24 +: 24] = 24'h000100 + 24'(i);
            req_a2[i*24 +: 24] = 24'h000200 + 24'(i);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ready("fair", r);
            expg = 4'b0001 << (k % 4);
            check("fair_grant", 64'(r), 64'(expg));
            check("fair_a1", 64'(eng_a1), 64'(24'h100 + 24'(k % 4)));
            if (k > 0) check("fair_b2b_gap", 64'(t_rdy - t_rsp), 64'(2));
            if (k == 4) req_valid = '0;
            wait_rsp("fair", v);
            check("fair_rspv", 64'(v), 64'(expg));
        end

        // Overflowing product on requester 1
        eng_dly = 2; m_w = 32'hFE000001; m_l = 6'd8; m_ovf = 1'b1;
        @(negedge clk);
        req_a1[24 +: 24] = 24'hFFFFFF;
        req_a2[24 +: 24] = 24'hFFFFFF;
        req_valid = 4'b0010;
        wait_ready("ovf", r);
        check("ovf_grant", 64'(r), 64'(4'b0010));
        check("ovf_a1", 64'(eng_a1), 64'(24'hFFFFFF));
        req_valid = '0;
        wait_rsp("ovf", v);
        check("ovf_rspv", 64'(v), 64'(4'b0010));
        check("ovf_w", 64'(rsp_w), 64'(32'hFE000001));
        check("ovf_l", 64'(rsp_l), 64'(8));
        check("ovf_flag", 64'(rsp_ovf), 64'(1));
        check("ovf_err", 64'(rsp_err), 64'(0));

        // Timeout on requester 2 (engine never answers)
        eng_dly = -1;
        @(negedge clk);
        req_valid = 4'b0100;
        wait_ready("tmo", r);
        check("tmo_grant", 64'(r), 64'(4'b0100));
        req_valid = '0;
        wait_rsp("tmo", v);
        check("tmo_rspv", 64'(v), 64'(4'b0100));
        check("tmo_lat", 64'(t_rsp - t_rdy), 64'(64));
        check("tmo_err", 64'(rsp_err), 64'(1));
        check("tmo_w", 64'(rsp_w), 64'(0));
        check("tmo_l", 64'(rsp_l), 64'(0));
        check("tmo_ovf", 64'(rsp_ovf), 64'(0));
        @(negedge clk);
        check("tmo_errs", 64'(err_count), 64'(1));
        check("tmo_jobs", 64'(job_count), 64'(7));

        // Pointer advanced past 2: with 2 and 3 pending, 3 wins; fastest possible done
        eng_dly = 0; m_w = 32'h12345678; m_l = 6'd13; m_ovf = 1'b0;
        req_valid = 4'b1100;
        wait_ready("rr", r);
        check("rr_grant", 64'(r), 64'(4'b1000));
        req_valid = 4'b0100;
        wait_rsp("rr", v);
        check("rr_rspv", 64'(v), 64'(4'b1000));
        check("rr_min_lat", 64'(t_rsp - t_rdy), 64'(1));
        check("rr_w", 64'(rsp_w), 64'(32'h12345678));
        eng_dly = 2;
        wait_ready("b2b", r);
        check("b2b_grant", 64'(r), 64'(4'b0100));
        check("b2b_gap", 64'(t_rdy - t_rsp), 64'(2));
        req_valid = '0;
        wait_rsp("b2b", v);
        check("b2b_rspv", 64'(v), 64'(4'b0100));

        // Enable gating, then en dropped mid-job must not abort it
        @(negedge clk);
        en = 1'b0;
        req_valid = 4'b0100;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) seen++;
        end
        check("en_block", 64'(seen), 64'(0));
        en = 1'b1;
        @(negedge clk);
        check("en_grant", 64'(req_ready), 64'(4'b0100));
        req_valid = '0;
        en = 1'b0;
        wait_rsp("en", v);
        check("en_wait_rspv", 64'(v), 64'(4'b0100));
        en = 1'b1;
        @(negedge clk);
        check("pre_rst_jobs", 64'(job_count), 64'(10));

        // Reset mid-WAIT abandons the job; the late done is ignored
        eng_dly = 5;
        req_valid = 4'b0001;
        wait_ready("rstw", r);
        check("rstw_grant", 64'(r), 64'(4'b0001));
        req_valid = '0;
        @(negedge clk);
        check("rstw_busy", 64'(busy), 64'(1));
        #2 n_reset = 1'b0;
        #1;
        check("rstw_busy0", 64'(busy), 64'(0));
        check("rstw_jobs0", 64'(job_count), 64'(0));
        check("rstw_errs0", 64'(err_count), 64'(0));
        check("rstw_w0", 64'(rsp_w), 64'(0));
        check("rstw_a1", 64'(eng_a1), 64'(0));
        @(negedge clk);
        n_reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0 || busy) seen++;
        end
        check("rstw_no_rsp", 64'(seen), 64'(0));
        check("rstw_jobs", 64'(job_count), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
